// File: rtl/if_stage_pkg.sv
// Shared selector encodings, state encoding and helpers for the fetch stage.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

  // Next-PC mux inputs, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    NPC_SEL_BOOT = 3'd0,
    NPC_SEL_EX   = 3'd1,
    NPC_SEL_HOLD = 3'd2,
    NPC_SEL_ID   = 3'd3,
    NPC_SEL_SEQ  = 3'd4
  } npc_sel_e;

  localparam int unsigned NPC_SEL_NUM_INPUTS = 5;

  typedef enum logic {
    IF_STATE_BOOT = 1'b0,
    IF_STATE_RUN  = 1'b1
  } if_state_e;

  // Instructions are word aligned; low address bits are dropped silently.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// IF<->ID/EX control bundle: redirect/stall inputs and the PC/valid fed to ID.
interface if_stage_if;
  logic        ex_flush;
  logic [31:0] ex_pc_target;
  logic [31:0] if_pc_target;
  logic        if_target_taken;
  logic        id_stall;
  logic [31:0] id_pc;
  logic        id_inst_valid;

  modport master (
    input  ex_flush, ex_pc_target, if_pc_target, if_target_taken, id_stall,
    output id_pc, id_inst_valid
  );

  modport slave (
    output ex_flush, ex_pc_target, if_pc_target, if_target_taken, id_stall,
    input  id_pc, id_inst_valid
  );
endinterface

// File: rtl/if_perf_ctr.sv
// Free-running event counter with enable; wraps modulo 2^CNT_W.
module if_perf_ctr #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count one event per enabled edge; cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: owns the fetch PC, selects next PC and drives the
// synchronous-read BIOS/IMEM addresses so data lines up with id_pc.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned BIOS_AW  = 12,
  parameter int unsigned IMEM_AW  = 14,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  if_stage_if.master         io_bus,
  output logic [BIOS_AW-1:0] o_bios_addr,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic [CNT_W-1:0]   o_fetch_count,
  output logic [CNT_W-1:0]   o_redirect_count
);

  if_state_e   r_state;
  if_state_e   w_state_d;
  logic [31:0] r_pc;
  logic        r_inst_valid;
  npc_sel_e    w_sel;
  logic [31:0] w_npc_in [NPC_SEL_NUM_INPUTS];
  logic [31:0] w_next_pc;
  logic        w_run;
  logic        w_fetch_en;
  logic        w_redirect_en;

  // State register; BOOT is held while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IF_STATE_BOOT;
    end else begin
      r_state <= w_state_d;
    end
  end

  // BOOT lasts a single edge; RUN is only left through reset.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IF_STATE_BOOT: w_state_d = IF_STATE_RUN;
      IF_STATE_RUN:  w_state_d = IF_STATE_RUN;
    endcase
  end

  // Next-PC select; stall outranks the ID redirect, which ID re-asserts later.
  always_comb begin
    w_sel = NPC_SEL_SEQ;
    if (r_state == IF_STATE_BOOT) begin
      w_sel = NPC_SEL_BOOT;
    end else if (io_bus.ex_flush) begin
      w_sel = NPC_SEL_EX;
    end else if (io_bus.id_stall) begin
      w_sel = NPC_SEL_HOLD;
    end else if (io_bus.if_target_taken) begin
      w_sel = NPC_SEL_ID;
    end
  end

  assign w_npc_in[NPC_SEL_BOOT] = RESET_PC;
  assign w_npc_in[NPC_SEL_EX]   = io_bus.ex_pc_target;
  assign w_npc_in[NPC_SEL_HOLD] = r_pc;
  assign w_npc_in[NPC_SEL_ID]   = io_bus.if_pc_target;
  assign w_npc_in[NPC_SEL_SEQ]  = r_pc + 32'd4;

  assign w_next_pc = align_word(w_npc_in[w_sel]);

  // Fetch PC register; loads RESET_PC on the BOOT edge via the mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // Memory data is valid from the first RUN cycle onward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst_valid <= 1'b0;
    end else begin
      r_inst_valid <= (w_state_d == IF_STATE_RUN);
    end
  end

  assign w_run         = (r_state == IF_STATE_RUN);
  assign w_fetch_en    = w_run & r_inst_valid & ~io_bus.id_stall & ~io_bus.ex_flush;
  assign w_redirect_en = w_run & (io_bus.ex_flush | (io_bus.if_target_taken & ~io_bus.id_stall));

  if_perf_ctr #(
    .CNT_W (CNT_W)
  ) u_fetch_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_fetch_en),
    .o_count (o_fetch_count)
  );

  if_perf_ctr #(
    .CNT_W (CNT_W)
  ) u_redirect_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_redirect_en),
    .o_count (o_redirect_count)
  );

  assign o_bios_addr          = w_next_pc[BIOS_AW+1:2];
  assign o_imem_addr          = w_next_pc[IMEM_AW+1:2];
  assign io_bus.id_pc         = r_pc;
  assign io_bus.id_inst_valid = r_inst_valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized
// traffic checked against a cycle-level model of the fetch rules.
module tb_if_stage;

  localparam logic [31:0] RstPc  = 32'h4000_0000;
  localparam int unsigned BiosAw = 12;
  localparam int unsigned ImemAw = 14;
  localparam int unsigned CntW   = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [BiosAw-1:0] bios_addr;
  logic [ImemAw-1:0] imem_addr;
  logic [CntW-1:0]   fetch_count;
  logic [CntW-1:0]   redirect_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_boot;
  logic        m_valid;
  logic [31:0] m_fc;
  logic [31:0] m_rc;

  always #5 clk = ~clk;

  if_stage_if u_if ();

  if_stage #(
    .RESET_PC (RstPc),
    .BIOS_AW  (BiosAw),
    .IMEM_AW  (ImemAw),
    .CNT_W    (CntW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .io_bus           (u_if.master),
    .o_bios_addr      (bios_addr),
    .o_imem_addr      (imem_addr),
    .o_fetch_count    (fetch_count),
    .o_redirect_count (redirect_count)
  );

  task automatic drive(input logic fl, input logic [31:0] ext, input logic tk,
                       input logic [31:0] ift, input logic st);
    u_if.ex_flush        = fl;
    u_if.ex_pc_target    = ext;
    u_if.if_target_taken = tk;
    u_if.if_pc_target    = ift;
    u_if.id_stall        = st;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic model_reset();
    m_pc = RstPc; m_boot = 1'b1; m_valid = 1'b0; m_fc = 32'd0; m_rc = 32'd0;
  endtask

  // Address the fetch unit should present this cycle.
  function automatic logic [31:0] exp_npc();
    logic [31:0] t;
    if (m_boot)                    t = RstPc;
    else if (u_if.ex_flush)        t = u_if.ex_pc_target;
    else if (u_if.id_stall)        t = m_pc;
    else if (u_if.if_target_taken) t = u_if.if_pc_target;
    else                           t = m_pc + 32'd4;
    return t & 32'hFFFF_FFFC;
  endfunction

  // Advance one clock edge and update the model; returns #1 after the edge.
  task automatic tick();
    logic [31:0] npc;
    logic fl, tk, st;
    npc = exp_npc();
    fl = u_if.ex_flush; tk = u_if.if_target_taken; st = u_if.id_stall;
    @(posedge clk);
    #1;
    if (!m_boot) begin
      if (m_valid && !st && !fl) m_fc = m_fc + 32'd1;
      if (fl || (tk && !st))     m_rc = m_rc + 32'd1;
    end
    m_pc = npc; m_valid = 1'b1; m_boot = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (u_if.id_pc !== RstPc) begin
      n_fail++; $display("FAIL reset_pc: got %h expected %h", u_if.id_pc, RstPc);
    end
    n_tests++;
    if (u_if.id_inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", u_if.id_inst_valid);
    end
    n_tests++;
    if (fetch_count !== 32'd0 || redirect_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", fetch_count, redirect_count);
    end
    n_tests++;
    if (bios_addr !== RstPc[BiosAw+1:2] || imem_addr !== RstPc[ImemAw+1:2]) begin
      n_fail++; $display("FAIL reset_addr: got %h/%h expected %h/%h", bios_addr, imem_addr,
                         RstPc[BiosAw+1:2], RstPc[ImemAw+1:2]);
    end
  endtask

  // Release reset between edges with no events and follow the boot sequence.
  task automatic test_boot();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (imem_addr !== 14'h0000 || u_if.id_inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL boot_addr: got %h/%b expected 0000/0", imem_addr, u_if.id_inst_valid);
    end
    tick();
    n_tests++;
    if (u_if.id_pc !== 32'h4000_0000 || u_if.id_inst_valid !== 1'b1 || imem_addr !== 14'h0001) begin
      n_fail++; $display("FAIL boot_edge1: got %h/%b/%h expected 40000000/1/0001",
                         u_if.id_pc, u_if.id_inst_valid, imem_addr);
    end
    tick();
    n_tests++;
    if (u_if.id_pc !== 32'h4000_0004 || imem_addr !== 14'h0002 || bios_addr !== 12'h002) begin
      n_fail++; $display("FAIL boot_edge2: got %h/%h/%h expected 40000004/0002/002",
                         u_if.id_pc, imem_addr, bios_addr);
    end
    tick();
    tick();
    n_tests++;
    if (fetch_count !== 32'd3 || redirect_count !== 32'd0) begin
      n_fail++; $display("FAIL boot_fetch_count: got %0d/%0d expected 3/0", fetch_count, redirect_count);
    end
  endtask

  task automatic test_redirect();
    tick();
    n_tests++;
    if (u_if.id_pc !== 32'h4000_0010) begin
      n_fail++; $display("FAIL redir_start_pc: got %h expected 40000010", u_if.id_pc);
    end
    drive(1'b0, 32'h0, 1'b1, 32'h4000_0102, 1'b0);
    #1;
    n_tests++;
    if (imem_addr !== 14'h0040 || bios_addr !== 12'h040) begin
      n_fail++; $display("FAIL redir_addr: got %h/%h expected 0040/040", imem_addr, bios_addr);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (u_if.id_pc !== 32'h4000_0100 || redirect_count !== 32'd1) begin
      n_fail++; $display("FAIL redir_pc: got %h/%0d expected 40000100/1", u_if.id_pc, redirect_count);
    end
    n_tests++;
    if (imem_addr !== 14'h0041) begin
      n_fail++; $display("FAIL redir_next_addr: got %h expected 0041", imem_addr);
    end
    tick();
    n_tests++;
    if (u_if.id_pc !== 32'h4000_0104) begin
      n_fail++; $display("FAIL redir_next_pc: got %h expected 40000104", u_if.id_pc);
    end
  endtask

  task automatic test_stall();
    logic [31:0] fc0;
    drive(1'b1, 32'h1000_0020, 1'b0, 32'h0, 1'b0);
    tick();
    n_tests++;
    if (u_if.id_pc !== 32'h1000_0020) begin
      n_fail++; $display("FAIL stall_setup_pc: got %h expected 10000020", u_if.id_pc);
    end
    fc0 = m_fc;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (imem_addr !== 14'h0008 || bios_addr !== 12'h008) begin
        n_fail++; $display("FAIL stall_addr[%0d]: got %h/%h expected 0008/008", i, imem_addr, bios_addr);
      end
      tick();
      n_tests++;
      if (u_if.id_pc !== 32'h1000_0020 || fetch_count !== fc0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h/%0d expected 10000020/%0d",
                           i, u_if.id_pc, fetch_count, fc0);
      end
    end
    idle();
    tick();
    n_tests++;
    if (u_if.id_pc !== 32'h1000_0024) begin
      n_fail++; $display("FAIL stall_release: got %h expected 10000024", u_if.id_pc);
    end
  endtask

  task automatic test_priority();
    logic [31:0] fc0, rc0;
    fc0 = m_fc; rc0 = m_rc;
    drive(1'b1, 32'h1000_0080, 1'b1, 32'h1234_5678, 1'b1);
    tick();
    idle();
    n_tests++;
    if (u_if.id_pc !== 32'h1000_0080) begin
      n_fail++; $display("FAIL prio_pc: got %h expected 10000080", u_if.id_pc);
    end
    n_tests++;
    if (redirect_count !== rc0 + 32'd1 || fetch_count !== fc0) begin
      n_fail++; $display("FAIL prio_counts: got %0d/%0d expected %0d/%0d",
                         redirect_count, fetch_count, rc0 + 32'd1, fc0);
    end
    // Stall with an ID redirect drops the redirect.
    rc0 = m_rc;
    drive(1'b0, 32'h0, 1'b1, 32'h2000_0000, 1'b1);
    tick();
    idle();
    n_tests++;
    if (u_if.id_pc !== 32'h1000_0080 || redirect_count !== rc0) begin
      n_fail++; $display("FAIL stall_drops_redir: got %h/%0d expected 10000080/%0d",
                         u_if.id_pc, redirect_count, rc0);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0);
    tick();
    idle();
    n_tests++;
    if (u_if.id_pc !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_align: got %h expected fffffffc", u_if.id_pc);
    end
    tick();
    n_tests++;
    if (u_if.id_pc !== 32'h0000_0000) begin
      n_fail++; $display("FAIL wrap_pc: got %h expected 00000000", u_if.id_pc);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    test_reset();
    @(posedge clk);
    #1;
    n_tests++;
    if (u_if.id_pc !== RstPc || u_if.id_inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_held: got %h/%b expected %h/0", u_if.id_pc, u_if.id_inst_valid, RstPc);
    end
    test_boot();
  endtask

  // Events asserted during the boot edge must be ignored.
  task automatic test_boot_ignores();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    drive(1'b1, 32'h1000_0040, 1'b1, 32'h2000_0040, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    idle();
    n_tests++;
    if (u_if.id_pc !== RstPc || fetch_count !== 32'd0 || redirect_count !== 32'd0) begin
      n_fail++; $display("FAIL boot_ignores: got %h/%0d/%0d expected %h/0/0",
                         u_if.id_pc, fetch_count, redirect_count, RstPc);
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    logic [31:0] t0, t1;
    for (int i = 0; i < 400; i++) begin
      t0 = $urandom();
      t1 = $urandom();
      drive(($urandom_range(0, 7) == 0), t0, ($urandom_range(0, 3) == 0), t1,
            ($urandom_range(0, 3) == 0));
      #1;
      e = exp_npc();
      n_tests++;
      if (imem_addr !== e[ImemAw+1:2] || bios_addr !== e[BiosAw+1:2]) begin
        n_fail++; $display("FAIL rand_addr[%0d]: got %h/%h expected %h/%h", i, imem_addr, bios_addr,
                           e[ImemAw+1:2], e[BiosAw+1:2]);
      end
      tick();
      n_tests++;
      if (u_if.id_pc !== m_pc || u_if.id_inst_valid !== m_valid) begin
        n_fail++; $display("FAIL rand_pc[%0d]: got %h/%b expected %h/%b", i, u_if.id_pc,
                           u_if.id_inst_valid, m_pc, m_valid);
      end
      n_tests++;
      if (fetch_count !== m_fc || redirect_count !== m_rc) begin
        n_fail++; $display("FAIL rand_counts[%0d]: got %0d/%0d expected %0d/%0d", i,
                           fetch_count, redirect_count, m_fc, m_rc);
      end
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    #12;
    test_reset();
    test_boot();
    test_redirect();
    test_stall();
    test_priority();
    test_wrap();
    test_async_reset();
    test_boot_ignores();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
